// File: rtl/ls_dcache_pkg.sv
// Shared types and constants for the LS D-Cache access controller.
// Struct field widths are the default LS address/data/tag widths.
package ls_dcache_pkg;

  localparam int LS_ADDR_W = 16;
  localparam int LS_DATA_W = 16;
  localparam int LS_TAG_W  = 5;

  localparam logic       LS_LOAD         = 1'b1;
  localparam logic       LS_STORE        = 1'b0;
  localparam logic [7:0] DCC_TIMEOUT_MAX = 8'd255;

  typedef struct packed {
    logic                 mode;
    logic [LS_ADDR_W-1:0] addr;
    logic [LS_DATA_W-1:0] data;
    logic [LS_TAG_W-1:0]  px;
    logic [LS_TAG_W-1:0]  tag_rob;
  } ls_req_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DRAIN
  } dcc_state_e;

endpackage

// File: rtl/ls_req_fifo.sv
// In-order LS request FIFO: registered count, head readable combinationally.
// clear empties it on the next edge and takes priority over push/pop.
module ls_req_fifo
  import ls_dcache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  ls_req_t                push_data,
  input  logic                   pop,
  input  logic                   clear,
  output ls_req_t                head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ls_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/ls_dcache_ctrl.sv
// LS D-Cache access controller: FIFO-buffered, one access in flight, held until ack; result 1 cycle after ack.
// Backpressure via req_ready_out (FIFO not full). Optional access timeout: define LS_DCC_TIMEOUT_EN.
module ls_dcache_ctrl
  import ls_dcache_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = LS_ADDR_W,
  parameter int DATA_W = LS_DATA_W,
  parameter int TAG_W  = LS_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic              req_mode_in,
  input  logic [ADDR_W-1:0] req_addr_in,
  input  logic [DATA_W-1:0] req_data_in,
  input  logic [TAG_W-1:0]  req_px_in,
  input  logic [TAG_W-1:0]  req_tag_rob_in,
  output logic              dc_read_req_out,
  output logic              dc_write_req_out,
  output logic [29:0]       dc_addr_out,
  output logic [3:0]        dc_byte_w_en_out,
  output logic [31:0]       dc_wdata_out,
  input  logic [31:0]       dc_rdata_in,
  input  logic              dc_ack_in,
  output logic              wb_valid_out,
  output logic [TAG_W-1:0]  wb_px_out,
  output logic [TAG_W-1:0]  wb_tag_rob_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic              st_done_valid_out,
  output logic [TAG_W-1:0]  st_done_tag_rob_out,
  output logic              err_timeout_out
);

  dcc_state_e            state_q, state_d;
  ls_req_t               active_q;
  ls_req_t               fifo_in;
  ls_req_t               fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  fifo_empty, fifo_full;
  logic                  push, pop, retire, busy, timeout_hit;
  logic                  unused_bits;

  assign req_ready_out = !fifo_full;
  assign push          = req_valid_in && req_ready_out && !flush_in;

  always_comb begin
    fifo_in         = '0;
    fifo_in.mode    = req_mode_in;
    fifo_in.addr    = LS_ADDR_W'(req_addr_in);
    fifo_in.data    = LS_DATA_W'(req_data_in);
    fifo_in.px      = LS_TAG_W'(req_px_in);
    fifo_in.tag_rob = LS_TAG_W'(req_tag_rob_in);
  end

  ls_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_in),
    .pop       (pop),
    .clear     (flush_in),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    retire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush_in && !fifo_empty) begin
          pop     = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (dc_ack_in || timeout_hit) begin
          // a flush coinciding with ack retires the access silently
          retire = dc_ack_in && !flush_in;
          if (!flush_in && !fifo_empty) begin
            pop     = 1'b1;
            state_d = ACCESS;
          end else begin
            state_d = IDLE;
          end
        end else if (flush_in) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dc_ack_in || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= IDLE;
      active_q            <= '0;
      wb_valid_out        <= 1'b0;
      wb_px_out           <= '0;
      wb_tag_rob_out      <= '0;
      wb_data_out         <= '0;
      st_done_valid_out   <= 1'b0;
      st_done_tag_rob_out <= '0;
    end else begin
      state_q           <= state_d;
      wb_valid_out      <= retire && (active_q.mode == LS_LOAD);
      st_done_valid_out <= retire && (active_q.mode == LS_STORE);
      if (pop) active_q <= fifo_head;
      if (retire && active_q.mode == LS_LOAD) begin
        wb_px_out      <= TAG_W'(active_q.px);
        wb_tag_rob_out <= TAG_W'(active_q.tag_rob);
        wb_data_out    <= dc_rdata_in[DATA_W-1:0];
      end
      if (retire && active_q.mode == LS_STORE) begin
        st_done_tag_rob_out <= TAG_W'(active_q.tag_rob);
      end
    end
  end

  // DRAIN keeps the request asserted: the cache cannot abandon an access midway
  assign busy             = (state_q != IDLE);
  assign dc_read_req_out  = busy && (active_q.mode == LS_LOAD);
  assign dc_write_req_out = busy && (active_q.mode == LS_STORE);
  assign dc_addr_out      = 30'(active_q.addr);
  assign dc_wdata_out     = 32'(active_q.data);
  assign dc_byte_w_en_out = dc_write_req_out ? 4'b1111 : 4'b0000;

`ifdef LS_DCC_TIMEOUT_EN
  logic [7:0] to_cnt_q;
  logic       err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (pop || dc_ack_in || !busy) to_cnt_q <= '0;
      else                           to_cnt_q <= to_cnt_q + 8'd1;
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign timeout_hit     = busy && !dc_ack_in && (to_cnt_q == DCC_TIMEOUT_MAX);
  assign err_timeout_out = err_q;
`else
  assign timeout_hit     = 1'b0;
  assign err_timeout_out = 1'b0;
`endif

  assign unused_bits = ^{dc_rdata_in, fifo_count};

endmodule

// File: tb/tb_ls_dcache_ctrl.sv
// Directed bench for ls_dcache_ctrl: expected cache accesses and completions are queued at
// issue time; two negedge monitors pop and compare whenever the DUT presents them.
module tb_ls_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_mode_in;
  logic [15:0] req_addr_in;
  logic [15:0] req_data_in;
  logic [4:0]  req_px_in;
  logic [4:0]  req_tag_rob_in;
  logic        dc_read_req_out;
  logic        dc_write_req_out;
  logic [29:0] dc_addr_out;
  logic [3:0]  dc_byte_w_en_out;
  logic [31:0] dc_wdata_out;
  logic [31:0] dc_rdata_in;
  logic        dc_ack_in;
  logic        wb_valid_out;
  logic [4:0]  wb_px_out;
  logic [4:0]  wb_tag_rob_out;
  logic [15:0] wb_data_out;
  logic        st_done_valid_out;
  logic [4:0]  st_done_tag_rob_out;
  logic        err_timeout_out;

  ls_dcache_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush_in            (flush_in),
    .req_valid_in        (req_valid_in),
    .req_ready_out       (req_ready_out),
    .req_mode_in         (req_mode_in),
    .req_addr_in         (req_addr_in),
    .req_data_in         (req_data_in),
    .req_px_in           (req_px_in),
    .req_tag_rob_in      (req_tag_rob_in),
    .dc_read_req_out     (dc_read_req_out),
    .dc_write_req_out    (dc_write_req_out),
    .dc_addr_out         (dc_addr_out),
    .dc_byte_w_en_out    (dc_byte_w_en_out),
    .dc_wdata_out        (dc_wdata_out),
    .dc_rdata_in         (dc_rdata_in),
    .dc_ack_in           (dc_ack_in),
    .wb_valid_out        (wb_valid_out),
    .wb_px_out           (wb_px_out),
    .wb_tag_rob_out      (wb_tag_rob_out),
    .wb_data_out         (wb_data_out),
    .st_done_valid_out   (st_done_valid_out),
    .st_done_tag_rob_out (st_done_tag_rob_out),
    .err_timeout_out     (err_timeout_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ben;
    logic [15:0] hold;
  } dc_exp_t;

  typedef struct packed {
    logic        is_load;
    logic [4:0]  px;
    logic [4:0]  tag;
    logic [15:0] data;
  } wb_exp_t;

  dc_exp_t exp_dc_q[$];
  wb_exp_t exp_wb_q[$];
  dc_exp_t dc_e;
  wb_exp_t wb_e;
  int      checks = 0;
  int      errors = 0;
  int      hold_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic mode, input logic [15:0] addr, input logic [15:0] data,
                         input logic [4:0] px, input logic [4:0] tag);
    req_valid_in   = 1'b1;
    req_mode_in    = mode;
    req_addr_in    = addr;
    req_data_in    = data;
    req_px_in      = px;
    req_tag_rob_in = tag;
  endtask

  task automatic exp_dc(input logic rd, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] hold);
    exp_dc_q.push_back({rd, !rd, 30'(addr), (rd ? 32'h0 : 32'(wdata)),
                        (rd ? 4'b0000 : 4'b1111), hold});
  endtask

  task automatic exp_wb(input logic is_load, input logic [4:0] px, input logic [4:0] tag,
                        input logic [15:0] data);
    exp_wb_q.push_back({is_load, px, tag, data});
  endtask

  // cache side: compare each access when it is acknowledged, including how long it was held
  always @(negedge clk) begin
    if (!rst && (dc_read_req_out || dc_write_req_out)) begin
      hold_cnt++;
      if (dc_ack_in) begin
        if (exp_dc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dc_unexpected: got access addr 0x%0h, expected none", dc_addr_out);
        end else begin
          dc_e = exp_dc_q.pop_front();
          chk("dc_rd", dc_read_req_out, dc_e.rd);
          chk("dc_wr", dc_write_req_out, dc_e.wr);
          chk("dc_addr", dc_addr_out, dc_e.addr);
          chk("dc_wdata", dc_wdata_out, dc_e.wdata);
          chk("dc_ben", dc_byte_w_en_out, dc_e.ben);
          chk("dc_hold", hold_cnt, dc_e.hold);
        end
        hold_cnt = 0;
      end
    end else begin
      hold_cnt = 0;
    end
  end

  // completion side: every wb/st_done cycle must match the next expected completion
  always @(negedge clk) begin
    if (wb_valid_out || st_done_valid_out) begin
      if (exp_wb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got wb=%0b st_done=%0b, expected none",
                 wb_valid_out, st_done_valid_out);
      end else begin
        wb_e = exp_wb_q.pop_front();
        chk("wb_valid", wb_valid_out, wb_e.is_load);
        chk("st_done_valid", st_done_valid_out, !wb_e.is_load);
        if (wb_e.is_load) begin
          chk("wb_px", wb_px_out, wb_e.px);
          chk("wb_tag", wb_tag_rob_out, wb_e.tag);
          chk("wb_data", wb_data_out, wb_e.data);
        end else begin
          chk("st_done_tag", st_done_tag_rob_out, wb_e.tag);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    flush_in       = 1'b0;
    req_valid_in   = 1'b0;
    req_mode_in    = 1'b0;
    req_addr_in    = '0;
    req_data_in    = '0;
    req_px_in      = '0;
    req_tag_rob_in = '0;
    dc_rdata_in    = '0;
    dc_ack_in      = 1'b0;
    tick(3);
    chk("reset_outputs", {dc_read_req_out, dc_write_req_out, dc_byte_w_en_out, wb_valid_out,
                          st_done_valid_out, err_timeout_out}, 0);
    rst = 1'b0;
    chk("reset_ready", req_ready_out, 1'b1);

    // single load, acked on its third request cycle
    set_req(1'b1, 16'h0012, 16'h0, 5'd7, 5'd3);
    exp_dc(1'b1, 16'h0012, 16'h0, 16'd3);
    exp_wb(1'b1, 5'd7, 5'd3, 16'hABCD);
    tick(1);
    req_valid_in = 1'b0;
    chk("load_not_yet_issued", dc_read_req_out, 1'b0);
    tick(3);
    dc_ack_in = 1'b1; dc_rdata_in = 32'h0000ABCD;
    tick(1);
    dc_ack_in = 1'b0;
    tick(3);

    // single store, acked on its first request cycle
    set_req(1'b0, 16'h0040, 16'h1234, 5'd0, 5'd9);
    exp_dc(1'b0, 16'h0040, 16'h1234, 16'd1);
    exp_wb(1'b0, 5'd0, 5'd9, 16'h0);
    tick(1);
    req_valid_in = 1'b0;
    tick(1);
    dc_ack_in = 1'b1; dc_rdata_in = 32'hFFFF0000;
    tick(1);
    dc_ack_in = 1'b0;
    tick(3);

    // one load in flight plus four queued fills the FIFO; then ack tied high drains one per cycle
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("ready_before_full", req_ready_out, 1'b1);
      set_req(1'b1, 16'h0100 + 16'(i), 16'h0, 5'd10 + 5'(i), 5'(i));
      exp_dc(1'b1, 16'h0100 + 16'(i), 16'h0, (i == 0) ? 16'd4 : 16'd1);
      exp_wb(1'b1, 5'd10 + 5'(i), 5'(i), 16'h1000 + 16'(i));
      tick(1);
    end
    req_valid_in = 1'b0;
    chk("ready_low_when_full", req_ready_out, 1'b0);
    for (int i = 0; i < 5; i++) begin
      dc_ack_in = 1'b1; dc_rdata_in = 32'hBEEF1000 + 32'(i);
      tick(1);
    end
    dc_ack_in = 1'b0;
    chk("b2b_idle_after_drain", dc_read_req_out, 1'b0);
    tick(3);

    // flush with a load outstanding and two queued: DRAIN holds the access, queue is discarded
    set_req(1'b1, 16'h0200, 16'h0, 5'd4, 5'd12);
    exp_dc(1'b1, 16'h0200, 16'h0, 16'd4);
    tick(1);
    set_req(1'b1, 16'h0201, 16'h0, 5'd5, 5'd13);
    tick(1);
    set_req(1'b0, 16'h0202, 16'h7777, 5'd6, 5'd14);
    tick(1);
    req_valid_in = 1'b0;
    flush_in = 1'b1;
    tick(1);
    flush_in = 1'b0;
    chk("drain_holds_req", dc_read_req_out, 1'b1);
    chk("flush_fifo_empty_ready", req_ready_out, 1'b1);
    tick(1);
    dc_ack_in = 1'b1; dc_rdata_in = 32'h00005555;
    tick(1);
    dc_ack_in = 1'b0;
    chk("drain_to_idle", dc_read_req_out | dc_write_req_out, 1'b0);
    tick(1);
    chk("flushed_not_reissued", dc_read_req_out | dc_write_req_out, 1'b0);
    set_req(1'b1, 16'h0300, 16'h0, 5'd1, 5'd15);
    exp_dc(1'b1, 16'h0300, 16'h0, 16'd1);
    exp_wb(1'b1, 5'd1, 5'd15, 16'h0303);
    tick(1);
    req_valid_in = 1'b0;
    tick(1);
    dc_ack_in = 1'b1; dc_rdata_in = 32'h12340303;
    tick(1);
    dc_ack_in = 1'b0;
    tick(3);

    // flush in the same cycle as a load's ack, with one more load queued behind it
    set_req(1'b1, 16'h0400, 16'h0, 5'd2, 5'd16);
    exp_dc(1'b1, 16'h0400, 16'h0, 16'd1);
    tick(1);
    set_req(1'b1, 16'h0401, 16'h0, 5'd3, 5'd17);
    tick(1);
    req_valid_in = 1'b0;
    dc_ack_in = 1'b1; dc_rdata_in = 32'h0000DEAD;
    flush_in = 1'b1;
    tick(1);
    dc_ack_in = 1'b0;
    flush_in = 1'b0;
    chk("flush_ack_idle", dc_read_req_out | dc_write_req_out, 1'b0);
    tick(1);
    chk("flush_ack_no_reissue", dc_read_req_out | dc_write_req_out, 1'b0);
    chk("flush_ack_ready", req_ready_out, 1'b1);
    tick(2);

    // long access with no ack
    set_req(1'b1, 16'h0FFF, 16'h0, 5'd31, 5'd18);
`ifdef LS_DCC_TIMEOUT_EN
    tick(1);
    req_valid_in = 1'b0;
    tick(300);
    chk("timeout_dropped", dc_read_req_out, 1'b0);
    chk("timeout_err_set", err_timeout_out, 1'b1);
    tick(20);
    chk("timeout_err_sticky", err_timeout_out, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("timeout_err_cleared_by_rst", err_timeout_out, 1'b0);
`else
    exp_dc(1'b1, 16'h0FFF, 16'h0, 16'd300);
    exp_wb(1'b1, 5'd31, 5'd18, 16'hFFFF);
    tick(1);
    req_valid_in = 1'b0;
    tick(300);
    chk("long_access_still_held", dc_read_req_out, 1'b1);
    chk("no_timeout_err", err_timeout_out, 1'b0);
    dc_ack_in = 1'b1; dc_rdata_in = 32'hFFFFFFFF;
    tick(1);
    dc_ack_in = 1'b0;
`endif
    tick(4);

    chk("dc_expect_left", exp_dc_q.size(), 0);
    chk("wb_expect_left", exp_wb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
